// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly controller for the 32-point FFT stage.
// It latches an operand pair (A, B) and a twiddle index, looks up W in a
// ROM and drives the sequential twiddle multiplier with B and W. It then
// forms P = A + W*B and Q = A - W*B from the multiplier's W*B result.
//
// Handshake: an operand pair transfers on a clock edge where i_valid and
// o_ready are both high. o_ready is high only in IDLE, and i_valid is
// ignored in every other state. o_valid and o_err are single-cycle strobes
// and have no back-pressure. The multiplier result is taken on the first
// sampled i_tw_valid, from the second WAIT cycle on.
module fft_butterfly #(
  parameter int SCALE   = 1,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [7:0] i_a_re,
  input  logic [7:0] i_a_im,
  input  logic [7:0] i_b_re,
  input  logic [7:0] i_b_im,
  input  logic [3:0] i_k,
  output logic       o_tw_start,
  output logic [7:0] o_tw_x,
  output logic [7:0] o_tw_y,
  output logic [7:0] o_tw_c,
  output logic [8:0] o_tw_cps,
  output logic [8:0] o_tw_cms,
  input  logic [7:0] i_tw_re,
  input  logic [7:0] i_tw_im,
  input  logic       i_tw_valid,
  output logic [7:0] o_p_re,
  output logic [7:0] o_p_im,
  output logic [7:0] o_q_re,
  output logic [7:0] o_q_im,
  output logic       o_valid,
  output logic       o_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          take_res;
  logic          start_c;
  logic          err_c;

  logic [7:0]    a_re, a_im;
  logic [7:0]    tw_x, tw_y, tw_c;
  logic [8:0]    tw_cps, tw_cms;
  logic [7:0]    p_re, p_im, q_re, q_im;

  logic [25:0]   rom_word;
  logic [7:0]    rom_c;
  logic [8:0]    rom_cps, rom_cms;

  logic signed [8:0] sum_p_re, sum_p_im, sum_q_re, sum_q_im;

  // Narrow a 9-bit butterfly sum to 8 bits: halve (arithmetic shift) or saturate.
  function automatic logic [7:0] fit(input logic signed [8:0] s);
    if (SCALE != 0)
      return s[8:1];
    else if (s > 9'sd127)
      return 8'h7f;
    else if (s < -9'sd128)
      return 8'h80;
    else
      return s[7:0];
  endfunction

  // Twiddle ROM {c, c+s, c-s}: c = round(128 cos t) clipped, s = -round(128 sin t), t = 2*pi*k/32.
  always_comb begin
    rom_word = '0;
    case (i_k)
      4'd0:  rom_word = {8'sd127,   9'sd127,   9'sd127};
      4'd1:  rom_word = {8'sd126,   9'sd101,   9'sd151};
      4'd2:  rom_word = {8'sd118,   9'sd69,    9'sd167};
      4'd3:  rom_word = {8'sd106,   9'sd35,    9'sd177};
      4'd4:  rom_word = {8'sd91,    9'sd0,     9'sd182};
      4'd5:  rom_word = {8'sd71,   -9'sd35,    9'sd177};
      4'd6:  rom_word = {8'sd49,   -9'sd69,    9'sd167};
      4'd7:  rom_word = {8'sd25,   -9'sd101,   9'sd151};
      4'd8:  rom_word = {8'sd0,    -9'sd128,   9'sd128};
      4'd9:  rom_word = {-8'sd25,  -9'sd151,   9'sd101};
      4'd10: rom_word = {-8'sd49,  -9'sd167,   9'sd69};
      4'd11: rom_word = {-8'sd71,  -9'sd177,   9'sd35};
      4'd12: rom_word = {-8'sd91,  -9'sd182,   9'sd0};
      4'd13: rom_word = {-8'sd106, -9'sd177,  -9'sd35};
      4'd14: rom_word = {-8'sd118, -9'sd167,  -9'sd69};
      4'd15: rom_word = {-8'sd126, -9'sd151,  -9'sd101};
      default: rom_word = '0;
    endcase
  end

  assign rom_c   = rom_word[25:18];
  assign rom_cps = rom_word[17:9];
  assign rom_cms = rom_word[8:0];

  // 9-bit butterfly sums against the live multiplier result.
  assign sum_p_re = $signed({a_re[7], a_re}) + $signed({i_tw_re[7], i_tw_re});
  assign sum_p_im = $signed({a_im[7], a_im}) + $signed({i_tw_im[7], i_tw_im});
  assign sum_q_re = $signed({a_re[7], a_re}) - $signed({i_tw_re[7], i_tw_re});
  assign sum_q_im = $signed({a_im[7], a_im}) - $signed({i_tw_im[7], i_tw_im});

  // State register; reset aborts any butterfly in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state and strobes; cnt == 0 marks the blanked first WAIT cycle.
  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    take_res = 1'b0;
    start_c  = 1'b0;
    err_c    = 1'b0;
    case (state)
      IDLE: begin
        if (i_valid) begin
          accept  = 1'b1;
          state_n = START;
        end
      end
      START: begin
        start_c = 1'b1;
        state_n = WAIT;
      end
      WAIT: begin
        if ((cnt != '0) && i_tw_valid) begin
          take_res = 1'b1;
          state_n  = OUT;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          err_c   = 1'b1;
          state_n = IDLE;
        end
      end
      OUT: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Wait counter: cleared in START, counts WAIT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (state == START) cnt <= '0;
    else if (state == WAIT)  cnt <= cnt + 1'b1;
  end

  // Operand latch, ROM register and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_re   <= '0;
      a_im   <= '0;
      tw_x   <= '0;
      tw_y   <= '0;
      tw_c   <= '0;
      tw_cps <= '0;
      tw_cms <= '0;
      p_re   <= '0;
      p_im   <= '0;
      q_re   <= '0;
      q_im   <= '0;
    end else begin
      if (accept) begin
        a_re   <= i_a_re;
        a_im   <= i_a_im;
        tw_x   <= i_b_re;
        tw_y   <= i_b_im;
        tw_c   <= rom_c;
        tw_cps <= rom_cps;
        tw_cms <= rom_cms;
      end
      if (take_res) begin
        p_re <= fit(sum_p_re);
        p_im <= fit(sum_p_im);
        q_re <= fit(sum_q_re);
        q_im <= fit(sum_q_im);
      end
    end
  end

  assign o_ready    = (state == IDLE);
  assign o_tw_start = start_c;
  assign o_valid    = (state == OUT);
  assign o_err      = err_c;
  assign o_tw_x     = tw_x;
  assign o_tw_y     = tw_y;
  assign o_tw_c     = tw_c;
  assign o_tw_cps   = tw_cps;
  assign o_tw_cms   = tw_cms;
  assign o_p_re     = p_re;
  assign o_p_im     = p_im;
  assign o_q_re     = q_re;
  assign o_q_im     = q_im;

endmodule

// File: tb/tb_fft_butterfly.sv
// Bench for fft_butterfly: a SCALE=1 and a SCALE=0 instance share one
// stimulus stream. A behavioural model (trig ROM, real-valued halving or
// clamping, per-transaction cycle schedule) predicts every output on
// every cycle.
module tb_fft_butterfly;

  localparam int TMO = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT wiring ----------------
  logic       i_valid = 1'b0;
  logic [7:0] i_a_re = '0, i_a_im = '0, i_b_re = '0, i_b_im = '0;
  logic [3:0] i_k = '0;
  logic [7:0] i_tw_re = '0, i_tw_im = '0;
  logic       i_tw_valid = 1'b0;

  logic       rdy1, st1, val1, err1, rdy0, st0, val0, err0;
  logic [7:0] x1, y1, c1, pr1, pi1, qr1, qi1;
  logic [7:0] x0, y0, c0, pr0, pi0, qr0, qi0;
  logic [8:0] cps1, cms1, cps0, cms0;

  fft_butterfly #(.SCALE(1), .TIMEOUT(TMO)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(rdy1),
    .i_a_re(i_a_re), .i_a_im(i_a_im), .i_b_re(i_b_re), .i_b_im(i_b_im), .i_k(i_k),
    .o_tw_start(st1), .o_tw_x(x1), .o_tw_y(y1), .o_tw_c(c1),
    .o_tw_cps(cps1), .o_tw_cms(cms1),
    .i_tw_re(i_tw_re), .i_tw_im(i_tw_im), .i_tw_valid(i_tw_valid),
    .o_p_re(pr1), .o_p_im(pi1), .o_q_re(qr1), .o_q_im(qi1),
    .o_valid(val1), .o_err(err1)
  );

  fft_butterfly #(.SCALE(0), .TIMEOUT(TMO)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(rdy0),
    .i_a_re(i_a_re), .i_a_im(i_a_im), .i_b_re(i_b_re), .i_b_im(i_b_im), .i_k(i_k),
    .o_tw_start(st0), .o_tw_x(x0), .o_tw_y(y0), .o_tw_c(c0),
    .o_tw_cps(cps0), .o_tw_cms(cms0),
    .i_tw_re(i_tw_re), .i_tw_im(i_tw_im), .i_tw_valid(i_tw_valid),
    .o_p_re(pr0), .o_p_im(pi0), .o_q_re(qr0), .o_q_im(qi0),
    .o_valid(val0), .o_err(err0)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi($floor(x + 0.5));
    else          return -$rtoi($floor(-x + 0.5));
  endfunction

  function automatic real theta(input int k);
    return 2.0 * 3.14159265358979 * real'(k) / 32.0;
  endfunction

  function automatic int m_c(input int k);
    int v;
    v = rnd(128.0 * $cos(theta(k)));
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  function automatic int m_s(input int k);
    return -rnd(128.0 * $sin(theta(k)));
  endfunction

  function automatic int m_fit(input int sum, input int scale);
    if (scale != 0) return $rtoi($floor(real'(sum) / 2.0));
    if (sum > 127)  return 127;
    if (sum < -128) return -128;
    return sum;
  endfunction

  // Per-transaction schedule (relative to the accept cycle) and held values.
  bit m_active = 1'b0;
  bit m_tmo = 1'b0;
  int m_t0 = 0, m_out_r = 0, m_err_r = 0, m_end_r = 0;
  int h_c = 0, h_cps = 0, h_cms = 0, h_x = 0, h_y = 0;
  int n_c = 0, n_cps = 0, n_cms = 0, n_x = 0, n_y = 0;
  int h1[4], n1[4], h0[4], n0[4];

  task automatic reset_model();
    m_active = 1'b0;
    m_tmo = 1'b0;
    h_c = 0; h_cps = 0; h_cms = 0; h_x = 0; h_y = 0;
    for (int i = 0; i < 4; i++) begin h1[i] = 0; h0[i] = 0; end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin : cmp
    int r;
    bit tw_new, res_new;
    int e_rdy, e_st, e_val, e_err;
    int ec, ecps, ecms, ex, ey;
    int e1[4], e0[4];
    r = cyc - m_t0;
    if (!m_active) begin
      e_rdy = 1; e_st = 0; e_val = 0; e_err = 0;
    end else begin
      e_rdy = (r <= 0 || r >= m_end_r) ? 1 : 0;
      e_st  = (r == 1) ? 1 : 0;
      e_val = (!m_tmo && r == m_out_r) ? 1 : 0;
      e_err = (m_tmo && r == m_err_r) ? 1 : 0;
    end
    tw_new  = m_active && r >= 1;
    res_new = m_active && !m_tmo && r >= m_out_r;
    ec   = tw_new ? n_c   : h_c;
    ecps = tw_new ? n_cps : h_cps;
    ecms = tw_new ? n_cms : h_cms;
    ex   = tw_new ? n_x   : h_x;
    ey   = tw_new ? n_y   : h_y;
    for (int i = 0; i < 4; i++) begin
      e1[i] = res_new ? n1[i] : h1[i];
      e0[i] = res_new ? n0[i] : h0[i];
    end
    chk("ready1", {31'd0, rdy1}, e_rdy);  chk("ready0", {31'd0, rdy0}, e_rdy);
    chk("start1", {31'd0, st1}, e_st);    chk("start0", {31'd0, st0}, e_st);
    chk("valid1", {31'd0, val1}, e_val);  chk("valid0", {31'd0, val0}, e_val);
    chk("err1", {31'd0, err1}, e_err);    chk("err0", {31'd0, err0}, e_err);
    chk("tw_c1", $signed(c1), ec);        chk("tw_c0", $signed(c0), ec);
    chk("tw_cps1", $signed(cps1), ecps);  chk("tw_cps0", $signed(cps0), ecps);
    chk("tw_cms1", $signed(cms1), ecms);  chk("tw_cms0", $signed(cms0), ecms);
    chk("tw_x1", $signed(x1), ex);        chk("tw_x0", $signed(x0), ex);
    chk("tw_y1", $signed(y1), ey);        chk("tw_y0", $signed(y0), ey);
    chk("p_re1", $signed(pr1), e1[0]);    chk("p_im1", $signed(pi1), e1[1]);
    chk("q_re1", $signed(qr1), e1[2]);    chk("q_im1", $signed(qi1), e1[3]);
    chk("p_re0", $signed(pr0), e0[0]);    chk("p_im0", $signed(pi0), e0[1]);
    chk("q_re0", $signed(qr0), e0[2]);    chk("q_im0", $signed(qi0), e0[3]);
  end

  // ---------------- driver ----------------
  // Called at posedge+1 of a cycle where the DUT is idle. vstart is the
  // relative cycle from which the stub multiplier holds i_tw_valid high
  // (negative = never). Real W*B data appears from relative cycle 3 (WAIT #2);
  // earlier cycles carry junk. rst_at > 0 asserts reset in that cycle.
  task automatic run_txn(input logic [7:0] are, input logic [7:0] aim,
                         input logic [7:0] bre, input logic [7:0] bim,
                         input int k, input int vstart,
                         input logic [7:0] twre, input logic [7:0] twim,
                         input int rst_at);
    int sa_re, sa_im, sw_re, sw_im;
    if (m_active) begin
      h_c = n_c; h_cps = n_cps; h_cms = n_cms; h_x = n_x; h_y = n_y;
      if (!m_tmo) begin
        for (int i = 0; i < 4; i++) begin h1[i] = n1[i]; h0[i] = n0[i]; end
      end
    end
    sa_re = $signed(are); sa_im = $signed(aim);
    sw_re = $signed(twre); sw_im = $signed(twim);
    n_c = m_c(k); n_cps = m_c(k) + m_s(k); n_cms = m_c(k) - m_s(k);
    n_x = $signed(bre); n_y = $signed(bim);
    n1[0] = m_fit(sa_re + sw_re, 1); n1[1] = m_fit(sa_im + sw_im, 1);
    n1[2] = m_fit(sa_re - sw_re, 1); n1[3] = m_fit(sa_im - sw_im, 1);
    n0[0] = m_fit(sa_re + sw_re, 0); n0[1] = m_fit(sa_im + sw_im, 0);
    n0[2] = m_fit(sa_re - sw_re, 0); n0[3] = m_fit(sa_im - sw_im, 0);
    m_tmo = (vstart < 0);
    if (m_tmo) begin
      m_out_r = -1000; m_err_r = 1 + TMO; m_end_r = m_err_r + 1;
    end else begin
      m_out_r = ((vstart < 3) ? 3 : vstart) + 1; m_err_r = -1000; m_end_r = m_out_r + 1;
    end
    m_t0 = cyc;
    m_active = 1'b1;
    i_valid = 1'b1;
    i_a_re = are; i_a_im = aim; i_b_re = bre; i_b_im = bim; i_k = 4'(k);
    i_tw_valid = (vstart == 0);
    i_tw_re = 8'($urandom); i_tw_im = 8'($urandom);
    for (int r = 1; r <= m_end_r; r++) begin
      @(posedge clk); #1;
      if (r == rst_at) begin
        i_valid = 1'b0; i_tw_valid = 1'b0;
        #2 rst_n = 1'b0;
        reset_model();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
      if (r == m_end_r) begin
        i_valid = 1'b0; i_tw_valid = 1'b0;
      end else begin
        i_valid = 1'($urandom_range(0, 1));
        i_a_re = 8'($urandom); i_a_im = 8'($urandom);
        i_b_re = 8'($urandom); i_b_im = 8'($urandom); i_k = 4'($urandom);
        i_tw_valid = (vstart >= 0 && r >= vstart);
        if (r >= 3) begin i_tw_re = twre; i_tw_im = twim; end
        else begin i_tw_re = 8'($urandom); i_tw_im = 8'($urandom); end
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    for (int i = 0; i < 4; i++) begin h1[i] = 0; n1[i] = 0; h0[i] = 0; n0[i] = 0; end
    reset_model();
    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    idle_cycles(2);

    // Literal pins on the model itself.
    chk("pin_c0", m_c(0), 127);
    chk("pin_cps0", m_c(0) + m_s(0), 127);
    chk("pin_c4", m_c(4), 91);
    chk("pin_cps4", m_c(4) + m_s(4), 0);
    chk("pin_cms4", m_c(4) - m_s(4), 182);
    chk("pin_cps8", m_c(8) + m_s(8), -128);
    chk("pin_cms8", m_c(8) - m_s(8), 128);
    chk("pin_half_p", m_fit(10 + 40, 1), 25);
    chk("pin_half_q", m_fit(20 + 60, 1), 40);
    chk("pin_half_neg", m_fit(10 - 40, 1), -15);
    chk("pin_sat_hi", m_fit(200, 0), 127);
    chk("pin_sat_lo", m_fit(-200, 0), -128);

    // ROM entries 0, 4, 8.
    run_txn(8'd1, 8'd2, 8'd3, 8'd4, 0, 3, 8'd5, 8'd6, 0);
    run_txn(8'd7, 8'd8, 8'd9, 8'd10, 4, 3, 8'd11, 8'd12, 0);
    run_txn(8'd13, 8'd14, 8'd15, 8'd16, 8, 3, 8'd17, 8'd18, 0);
    idle_cycles(2);

    // Butterfly A=(10,20), W*B=(40,-60) at WAIT #2.
    run_txn(8'd10, 8'd20, 8'd33, 8'd44, 5, 3, 8'd40, -8'sd60, 0);
    // Saturation A=(100,-100), W*B=(100,-100).
    run_txn(8'd100, -8'sd100, 8'd1, 8'd2, 2, 3, 8'd100, -8'sd100, 0);
    // Blanking: i_tw_valid held high from before accept.
    run_txn(-8'sd128, 8'd127, 8'd50, -8'sd50, 12, 0, 8'd127, -8'sd128, 0);
    idle_cycles(3);
    // Timeout: multiplier never answers.
    run_txn(8'd55, 8'd66, 8'd77, 8'd88, 9, -1, 8'd0, 8'd0, 0);
    idle_cycles(2);
    // Reset during WAIT #2, then a normal transaction.
    run_txn(8'd21, 8'd22, 8'd23, 8'd24, 3, -1, 8'd0, 8'd0, 3);
    idle_cycles(2);
    run_txn(8'd31, -8'sd32, 8'd33, 8'd34, 15, 4, -8'sd70, 8'd90, 0);

    // Random transactions.
    for (int t = 0; t < 60; t++) begin
      run_txn(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 8)),
              8'($urandom), 8'($urandom), 0);
      if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end

    idle_cycles(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #500000;
    n_mis++;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
